esdi_serial_cmd_ctrl: RTL
=========================

Name: esdi_serial_cmd_ctrl

Overview:
Sequences the ESDI serial command/status channel: shifts a 16-bit command plus odd parity to the drive over command_data with a transfer_req/transfer_ack handshake, then waits for command_complete. Optionally reads back a 16-bit configuration/status word plus parity over confstat_data. Sits inside soc_bd between the AXI-Lite register block (software side) and the esdi_* pins; polarity inversion of req/data stays in top.

Parameters:
SYNC_STAGES, 2, flops per asynchronous drive input
SETUP_CYCLES, 4, aclk cycles command_data is stable before transfer_req rises
TIMEOUT_CYCLES, 1000000, maximum aclk cycles spent in any single wait state

Ports:
aclk  input  1  system clock
aresetn  input  1  reset; synchronous, active-low
cmd_valid  input  1  command request from register block
cmd_ready  output  1  high only in IDLE; command is accepted when cmd_valid && cmd_ready
cmd_word  input  16  command word; bit 15 is sent first
cmd_expect_status  input  1  read a 17-bit status frame after completion
rsp_valid  output  1  one-cycle pulse when the transaction ends
rsp_data  output  16  received status word; held until the next accept
rsp_parity_err  output  1  status parity error; held like rsp_data
rsp_timeout  output  1  transaction aborted by timeout; held like rsp_data
busy  output  1  high in any state other than IDLE
esdi_transfer_req  output  1  active-high internal request
esdi_command_data  output  1  active-high internal serial data
esdi_transfer_ack  input  1  asynchronous
esdi_confstat_data  input  1  asynchronous
esdi_command_complete  input  1  asynchronous

Behaviour:
- Synchronizers:
  - All three drive inputs pass through SYNC_STAGES flops.
  - Internal use sees them SYNC_STAGES cycles late, all with equal latency.
- Reset values: cmd_ready=1 (IDLE), rsp_valid=0, rsp_data=0, rsp_parity_err=0, rsp_timeout=0, busy=0, esdi_transfer_req=0, esdi_command_data=0; all synchronizer flops cleared.
- Reset mid-transaction: all outputs return to reset values on the next aclk edge and the FSM goes to IDLE. No rsp_valid is issued.
- Accept:
  - Latch the shift register {cmd_word, ~^cmd_word}: 17 bits, odd parity overall.
  - Bit counter = 16.
  - cc_seen_low = 0.
  - Clear the rsp_* flags.
  - Latch cmd_expect_status.
- States:
  - IDLE: wait for accept; go to C_SETUP.
  - C_SETUP: command_data = current shift register MSB; count SETUP_CYCLES; then go to C_REQ.
  - C_REQ: req=1; wait for ack_s=1; go to C_REL.
  - C_REL: req=0; wait for ack_s=0. Then:
    - if bit count is 0, go to WAIT_CC;
    - otherwise shift left, decrement, and go to C_SETUP.
  - WAIT_CC:
    - cc_seen_low is set whenever cc_s=0 in any non-IDLE state.
    - Exit when cc_seen_low && cc_s=1.
    - Go to S_REQ if status is expected (bit count = 16); otherwise go to DONE.
  - S_REQ: req=1; wait for ack_s=1; sample confstat_s into a 17-bit shift register (LSB in) in that same cycle; go to S_REL.
  - S_REL: req=0; wait for ack_s=0. Then:
    - if bit count is 0, go to DONE;
    - otherwise decrement and go to S_REQ.
  - DONE:
    - rsp_valid=1 for one cycle.
    - rsp_data = sreg[16:1].
    - rsp_parity_err = ~(^sreg) when status was read; 0 otherwise.
    - Go to IDLE.
- Timeout:
  - One counter, cleared on every state change, incremented in C_REQ, C_REL, WAIT_CC, S_REQ and S_REL.
  - When it reaches TIMEOUT_CYCLES:
    - drop req and command_data the next cycle;
    - rsp_timeout=1, rsp_valid pulse;
    - go to IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- command_data may change only in C_SETUP, and is held through C_REQ and C_REL.
- The ack_s polarity check is level-based. An ack already high on entry to C_REQ completes that bit immediately; this is legal per the drive handshake.
- cmd_valid while busy is ignored; no queueing.

Decomposition:
- esdi_pkg holds:
  - state enum;
  - ESDI_FRAME_BITS=17 and ESDI_WORD_BITS=16;
  - odd_parity function, shared with a future data-path block.
- Sub-module esdi_sync: a parameterised SYNC_STAGES-deep single-bit synchronizer, instanced three times.

Test Plan:
- Send cmd 0x1234 with expect=0 and a responsive drive model.
  - Required: 17 req pulses; serial bits 0001_0010_0011_0100 then parity 0.
  - Required: rsp_valid once after cc goes low→high; rsp_timeout=0.
- Send cmd 0x0000 with expect=1; the drive returns status 0x00FF with parity 1.
  - Required: command parity bit=1; rsp_data=0x00FF; rsp_parity_err=0.
- Same as above, but the drive sends status parity 0.
  - Required: rsp_parity_err=1; rsp_data=0x00FF.
- Run with TIMEOUT_CYCLES=50 and the drive never acks.
  - Required: req high for exactly 50 wait cycles, then req=0.
  - Required: rsp_valid with rsp_timeout=1; cmd_ready=1 the cycle after.
- Assert aresetn=0 for 1 cycle in the middle of bit 8.
  - Required: req=0, busy=0, cmd_ready=1 on the next edge; no rsp_valid.
  - Required: a new command then completes normally.
- Hold command_complete high throughout, with expect=0.
  - Required: the FSM stays in WAIT_CC until the drive pulses cc low then high; cmd_valid during busy is ignored.

Source files
------------

// File: rtl/esdi_pkg.sv
// Shared definitions for the ESDI serial command/status channel blocks.
// State encoding, frame geometry and the odd-parity helper used on both directions.
package esdi_pkg;

    localparam int ESDI_FRAME_BITS = 17;
    localparam int ESDI_WORD_BITS  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_C_SETUP,
        ST_C_REQ,
        ST_C_REL,
        ST_WAIT_CC,
        ST_S_REQ,
        ST_S_REL,
        ST_DONE
    } esdi_state_t;

    // Parity bit that makes {word, bit} contain an odd number of ones.
    function automatic logic odd_parity(input logic [ESDI_WORD_BITS-1:0] word);
        return ~^word;
    endfunction

endpackage

// File: rtl/esdi_sync.sv
// Single-bit multi-flop synchronizer for asynchronous drive inputs.
// Cleared by the synchronous active-low reset so stale drive levels never leak past reset.
module esdi_sync #(
    parameter int STAGES = 2
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/esdi_serial_cmd_ctrl.sv
// ESDI serial command/status sequencer: shifts a 17-bit command frame out with a
// req/ack handshake, waits for command complete, optionally reads a 17-bit status frame.
module esdi_serial_cmd_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_word,
    input  logic        cmd_expect_status,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_parity_err,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        esdi_transfer_req,
    output logic        esdi_command_data,
    input  logic        esdi_transfer_ack,
    input  logic        esdi_confstat_data,
    input  logic        esdi_command_complete
);

    import esdi_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SU_W = $clog2(SETUP_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SU_W-1:0] SU_LAST  = SU_W'(SETUP_CYCLES - 1);
    localparam logic [4:0]      BIT_LAST = 5'(ESDI_WORD_BITS);

    esdi_state_t state, next_state;

    logic ack_s, conf_s, cc_s;
    logic in_wait, timeout_hit;

    logic [ESDI_FRAME_BITS-1:0] cmd_sreg;
    logic [ESDI_FRAME_BITS-1:0] st_sreg;
    logic [4:0]                 bit_cnt;
    logic [SU_W-1:0]            setup_cnt;
    logic [TO_W-1:0]            to_cnt;
    logic                       cc_seen_low;
    logic                       expect_q;
    logic                       rsp_valid_q;
    logic [15:0]                rsp_data_q;
    logic                       rsp_parity_err_q;
    logic                       rsp_timeout_q;

    esdi_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .aclk    (aclk),
        .aresetn (aresetn),
        .d       (esdi_transfer_ack),
        .q       (ack_s)
    );

    esdi_sync #(.STAGES(SYNC_STAGES)) u_sync_conf (
        .aclk    (aclk),
        .aresetn (aresetn),
        .d       (esdi_confstat_data),
        .q       (conf_s)
    );

    esdi_sync #(.STAGES(SYNC_STAGES)) u_sync_cc (
        .aclk    (aclk),
        .aresetn (aresetn),
        .d       (esdi_command_complete),
        .q       (cc_s)
    );

    assign in_wait = state inside {ST_C_REQ, ST_C_REL, ST_WAIT_CC, ST_S_REQ, ST_S_REL};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A timeout in any wait state overrides the normal handshake transition.
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE:    if (cmd_valid) next_state = ST_C_SETUP;
            ST_C_SETUP: if (setup_cnt == SU_LAST) next_state = ST_C_REQ;
            ST_C_REQ:   if (ack_s) next_state = ST_C_REL;
            ST_C_REL:   if (!ack_s) next_state = (bit_cnt == 5'd0) ? ST_WAIT_CC : ST_C_SETUP;
            ST_WAIT_CC: if (cc_seen_low && cc_s) next_state = expect_q ? ST_S_REQ : ST_DONE;
            ST_S_REQ:   if (ack_s) next_state = ST_S_REL;
            ST_S_REL:   if (!ack_s) next_state = (bit_cnt == 5'd0) ? ST_DONE : ST_S_REQ;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
        if (in_wait && to_cnt == TO_LAST) begin
            timeout_hit = 1'b1;
            next_state  = ST_IDLE;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cmd_sreg         <= '0;
            st_sreg          <= '0;
            bit_cnt          <= '0;
            setup_cnt        <= '0;
            to_cnt           <= '0;
            cc_seen_low      <= 1'b0;
            expect_q         <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_data_q       <= '0;
            rsp_parity_err_q <= 1'b0;
            rsp_timeout_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;

            if (state == ST_C_SETUP && next_state == ST_C_SETUP) begin
                setup_cnt <= setup_cnt + SU_W'(1);
            end else begin
                setup_cnt <= '0;
            end

            if (next_state != state) begin
                to_cnt <= '0;
            end else if (in_wait) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (state != ST_IDLE && !cc_s) begin
                cc_seen_low <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_sreg         <= {cmd_word, odd_parity(cmd_word)};
                        st_sreg          <= '0;
                        bit_cnt          <= BIT_LAST;
                        cc_seen_low      <= 1'b0;
                        expect_q         <= cmd_expect_status;
                        rsp_data_q       <= '0;
                        rsp_parity_err_q <= 1'b0;
                        rsp_timeout_q    <= 1'b0;
                    end
                end
                ST_C_REL: begin
                    if (next_state == ST_C_SETUP) begin
                        cmd_sreg <= {cmd_sreg[ESDI_FRAME_BITS-2:0], 1'b0};
                        bit_cnt  <= bit_cnt - 5'd1;
                    end
                end
                ST_WAIT_CC: begin
                    if (next_state == ST_S_REQ) bit_cnt <= BIT_LAST;
                end
                ST_S_REQ: begin
                    if (next_state == ST_S_REL) begin
                        st_sreg <= {st_sreg[ESDI_FRAME_BITS-2:0], conf_s};
                    end
                end
                ST_S_REL: begin
                    if (next_state == ST_S_REQ) bit_cnt <= bit_cnt - 5'd1;
                end
                default: ;
            endcase

            // The command MSB is the serial data line, so clearing the frame drops it.
            if (state != ST_IDLE && next_state == ST_IDLE) begin
                cmd_sreg <= '0;
            end

            if (next_state == ST_DONE) begin
                rsp_valid_q      <= 1'b1;
                rsp_data_q       <= st_sreg[ESDI_FRAME_BITS-1:1];
                rsp_parity_err_q <= expect_q & ~(^st_sreg);
            end

            if (timeout_hit) begin
                rsp_valid_q   <= 1'b1;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign cmd_ready         = (state == ST_IDLE);
    assign busy              = (state != ST_IDLE);
    assign esdi_transfer_req = (state == ST_C_REQ) || (state == ST_S_REQ);
    assign esdi_command_data = cmd_sreg[ESDI_FRAME_BITS-1];
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rsp_data_q;
    assign rsp_parity_err    = rsp_parity_err_q;
    assign rsp_timeout       = rsp_timeout_q;

endmodule
